// File: rtl/sr_mdu_pkg.sv
// Shared types for the two-requester multiplier arbiter: FSM states and requester id.
package sr_mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/sr_mul_iter.sv
// Iterative shift-and-add multiplier: one partial-product step per cycle, fixed WIDTH steps.
module sr_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next_s;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;

    // Next accumulator value; done flags the cycle in which the final step lands.
    always_comb begin
        acc_next_s = acc_r;
        if (b_r[0]) begin
            acc_next_s = acc_r + a_r;
        end else begin
            acc_next_s = acc_r;
        end
        done    = busy_r && (cnt_r == LAST);
        product = acc_next_s;
    end

    // Operand/accumulator registers and step counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            a_r    <= a_in;
            b_r    <= b_in;
            acc_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b1;
        end else if (busy_r) begin
            a_r   <= a_r << 1;
            b_r   <= b_r >> 1;
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == LAST) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_mdu_arb.sv
// Round-robin arbiter sharing one iterative multiplier between two requesters,
// holding each result until the consumer takes it.
module sr_mdu_arb
    import sr_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    input  logic             rsp_ready
);

    state_t           state_r;
    state_t           state_next_s;
    req_id_t          last_r;
    req_id_t          grant_s;
    logic             any_valid_s;
    logic             accept_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;
    logic             rsp_valid_r;
    req_id_t          rsp_id_r;
    logic [WIDTH-1:0] rsp_result_r;

    // Grant selection from current valids; a tie goes to whoever was not served last.
    always_comb begin
        grant_s     = 1'b0;
        any_valid_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s     = ~last_r;
            any_valid_s = 1'b1;
        end else if (req0_valid) begin
            grant_s     = 1'b0;
            any_valid_s = 1'b1;
        end else if (req1_valid) begin
            grant_s     = 1'b1;
            any_valid_s = 1'b1;
        end else begin
            grant_s     = 1'b0;
            any_valid_s = 1'b0;
        end
    end

    // Ready is only offered in IDLE and out of reset, to the granted requester.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (state_r == IDLE) && any_valid_s) begin
            req0_ready = (grant_s == 1'b0);
            req1_ready = (grant_s == 1'b1);
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        accept_s = req0_ready || req1_ready;
        if (grant_s) begin
            op_a_s = req1_a;
            op_b_s = req1_b;
        end else begin
            op_a_s = req0_a;
            op_b_s = req0_b;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = BUSY;
                else          state_next_s = IDLE;
            end
            BUSY: begin
                if (mul_done_s) state_next_s = DONE;
                else            state_next_s = BUSY;
            end
            DONE: begin
                if (rsp_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, round-robin pointer and response hold registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_r       <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_result_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if ((state_r == IDLE) && accept_s) begin
                rsp_id_r <= grant_s;
            end else begin
                rsp_id_r <= rsp_id_r;
            end
            if ((state_r == BUSY) && mul_done_s) begin
                rsp_valid_r  <= 1'b1;
                rsp_result_r <= mul_product_s;
            end else if ((state_r == DONE) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
                last_r      <= rsp_id_r;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;

    sr_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   ((state_r == IDLE) && accept_s),
        .a_in    (op_a_s),
        .b_in    (op_b_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

endmodule

// File: doc/sr_mdu_arb.md
SR_MDU_ARB -- requirements
Module: sr_mdu_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N holds operands valid.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  multiplicand and multiplier per requester.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  requester N's operands are accepted this cycle.
REQ-007 SHALL have port rsp_valid  output  1  result available.
REQ-008 SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-009 SHALL have port rsp_result  output  WIDTH  product.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes the result.

Function
REQ-011 SHALL share one iterative multiplier between two requesters using FSM states IDLE, BUSY and DONE.
REQ-012 In IDLE, a request SHALL be granted when exactly one reqN_valid is high.
REQ-013 In IDLE with both reqN_valid high, the grant SHALL go to the requester not served last (round-robin pointer).
REQ-014 reqN_ready SHALL be high only in IDLE and only for the granted N; it is combinational from the current reqN_valid and the pointer.
REQ-015 An accept (reqN_valid and reqN_ready both high) SHALL latch a, b and id; the FSM then goes IDLE->BUSY.
REQ-016 BUSY SHALL last exactly WIDTH cycles; each cycle:
  - if b[0] is 1, then acc += a, truncated to WIDTH bits;
  - a <<= 1 and b >>= 1;
  - step counter increments.
REQ-017 BUSY->DONE SHALL occur after the WIDTH-th step; there is no early termination, so latency is fixed.
REQ-018 If the accept happens in cycle 0, rsp_valid SHALL first be high in cycle WIDTH+1.
REQ-019 rsp_result SHALL equal the low WIDTH bits of a*b; overflow bits are discarded, and signed and unsigned results are identical.
REQ-020 In DONE, rsp_valid SHALL stay high and rsp_result/rsp_id SHALL stay stable until rsp_ready is high.
REQ-021 On the rsp handshake, the FSM SHALL go DONE->IDLE and the round-robin pointer SHALL record rsp_id as last served.
REQ-022 No request SHALL be accepted in the handshake cycle; the earliest next accept is the following cycle, giving a peak throughput of one op per WIDTH+2 cycles.
REQ-023 reqN_ready SHALL be low in BUSY and DONE regardless of reqN_valid.
REQ-024 Requesters SHALL hold valid and operands until ready; arbitration uses only current-cycle valids, and a valid withdrawn before grant is ignored.
REQ-025 Operand changes on req ports during BUSY/DONE SHALL NOT affect the result in flight.
REQ-026 A zero operand SHALL still take the full WIDTH cycles and yield 0.

Reset
REQ-027 With rst_n low at a clock edge, the block SHALL apply these reset values:
  - state IDLE, step counter 0, acc 0;
  - rsp_valid 0, rsp_result 0, rsp_id 0;
  - round-robin pointer set so requester 0 wins the first tie.
REQ-028 While rst_n is low, req0_ready and req1_ready SHALL be 0.
REQ-029 Reset during BUSY or DONE SHALL abort the operation; no response is ever produced for it, and requests are accepted from the first cycle after rst_n goes high.

Structure
REQ-030 Package sr_mdu_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the requester-id type.
REQ-031 Datapath SHALL live in sub-module sr_mul_iter, containing:
  - a, b and acc registers and the step counter;
  - a start input and a done output.
REQ-032 sr_mdu_arb SHALL contain only arbitration, FSM, round-robin pointer and response-hold logic.
REQ-033 The block SHALL contain no combinational WIDTHxWIDTH multiplier; only an adder and shifters.

Verification
REQ-034 Single request: req0 3*5, rsp_ready=1 -> req0_ready in cycle 0; rsp_valid, rsp_id=0, rsp_result=15 in cycle 33 (WIDTH=32).
REQ-035 Tie and round-robin after reset:
  - both valid, req0 7*6, req1 0xFFFFFFFF*2 -> req0 served first, result 42;
  - then req1 served, result 0xFFFFFFFE;
  - both again -> req0 granted.
REQ-036 Overflow and zero:
  - 0x80000000*2 -> 0;
  - 0x00010000*0x00010000 -> 0;
  - 0*0x1234 -> 0, still at cycle 33.
REQ-037 Backpressure: rsp_ready low for 5 cycles in DONE -> rsp_valid, rsp_result and rsp_id held constant; req0_ready and req1_ready remain 0; IDLE is entered the cycle after rsp_ready rises.
REQ-038 Reset mid-op: assert rst_n=0 at BUSY step 10 -> no rsp_valid ever for that op; the next req1 9*9 after reset returns 81 with rsp_id=1.
